// File: rtl/esp32_uart_pkg.sv
// Shared UART definitions: FSM encodings and frame constants, reused by the receive side.
package esp32_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_MIN_DIV    = 2;

endpackage

// File: rtl/esp32_uart_tx_if.sv
// Byte handshake from the peripheral register block into the UART transmitter.
interface esp32_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/esp32_uart_fifo.sv
// Synchronous FIFO with registered read data, full/empty flags and occupancy level.
module esp32_uart_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned LevelW = AddrW + 1;
  localparam logic [LevelW-1:0] FullLevel = LevelW'(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic [Width-1:0]  rd_data_q;
  logic              do_push, do_pop;

  assign full_o    = (level_q == FullLevel);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;

  // Flags come from the registered level, so an empty FIFO never pops the byte being written.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + AddrW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/esp32_uart_tx.sv
// 8N1 UART transmitter for the ESP32 PMOD: FIFO-buffered, programmable bit period, optional CTS.
module esp32_uart_tx
  import esp32_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 17
) (
  input  logic                          clk_peripheral,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              baud_div,
  esp32_uart_tx_if.slave                tx,
  input  logic                          flow_en,
  input  logic                          cts_n,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(UART_MIN_DIV);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_start;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             uart_tx_q, uart_tx_d;
  logic             busy_q;
  logic             cts_meta_q, cts_sync_q, cts_ok;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic             bit_done, start_ok;

  assign tx.tx_ready = ~fifo_full & ~reset;
  assign fifo_push   = tx.tx_valid & tx.tx_ready;

  esp32_uart_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i     (clk_peripheral),
    .reset_i   (reset),
    .push_i    (fifo_push),
    .wr_data_i (tx.tx_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign cts_ok    = ~flow_en | ~cts_sync_q;
  assign start_ok  = ~fifo_empty & cts_ok;
  assign div_start = (baud_div < MinDiv) ? MinDiv : baud_div;
  assign bit_done  = (timer_q == '0);

  // The popped byte lands in the FIFO read register one cycle after the pop, so the shift
  // register is loaded at the end of the start bit rather than at the pop itself.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    if (state_q != StIdle) begin
      timer_d = timer_q - DivOne;
    end
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          fifo_pop  = 1'b1;
          div_d     = div_start;
          timer_d   = div_start - DivOne;
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          timer_d = div_q - DivOne;
          shift_d = fifo_rd_data;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d = div_q - DivOne;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          if (start_ok) begin
            fifo_pop  = 1'b1;
            div_d     = div_start;
            timer_d   = div_start - DivOne;
            bit_cnt_d = '0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    uart_tx_d = 1'b1;
    case (state_q)
      StStart: uart_tx_d = 1'b0;
      StData:  uart_tx_d = shift_q[0];
      default: uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      state_q    <= StIdle;
      div_q      <= MinDiv;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      // Registered so busy stays high until the stop bit has left the output flop.
      busy_q     <= ~fifo_empty | (state_q != StIdle);
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_esp32_uart_tx.sv
// Scoreboard bench for esp32_uart_tx: queued bytes are matched against frames decoded off the line.
module tb_esp32_uart_tx;
  import esp32_uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         div;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [16:0] baud_div;
  logic        flow_en;
  logic        cts_n;
  logic        uart_tx;
  logic        busy;
  logic [4:0]  fifo_level;

  esp32_uart_tx_if tx_if ();

  esp32_uart_tx #(
    .FIFO_DEPTH (16),
    .DIV_W      (17)
  ) dut (
    .clk_peripheral (clk),
    .reset          (reset),
    .baud_div       (baud_div),
    .tx             (tx_if),
    .flow_en        (flow_en),
    .cts_n          (cts_n),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_frames = 0;
  bit   in_frame = 0;
  bit   abort    = 0;
  sb_t  sb_q [$];
  int   start_q [$];
  int   last_accept;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pop_start();
    if (start_q.size() == 0) return -1;
    return start_q.pop_front();
  endfunction

  task automatic push_byte(input logic [7:0] data, input int div, input logic expect_acc);
    @(negedge clk);
    check_eq("tx_ready", {31'd0, tx_if.tx_ready}, {31'd0, expect_acc});
    tx_if.tx_data  = data;
    tx_if.tx_valid = 1'b1;
    if (expect_acc) sb_q.push_back('{data: data, div: div});
    @(negedge clk);
    last_accept    = cyc;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (n_frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_start", n_frames, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || in_frame || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_sb", sb_q.size(), 0);
    check_eq("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  // Line monitor: samples every cycle of every bit, so bit values and bit lengths are both checked.
  initial begin : monitor
    sb_t        e;
    logic [9:0] obs, expw;
    bit         bad, aborted;
    forever begin
      @(negedge clk);
      if (!abort && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        n_frames++;
        in_frame = 1;
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", sb_q.size(), 1);
          e.data = 8'h00;
          e.div  = 2;
        end else begin
          e = sb_q.pop_front();
        end
        expw    = {1'b1, e.data, 1'b0};
        obs     = '0;
        bad     = 0;
        aborted = 0;
        for (int b = 0; b < int'(UART_FRAME_BITS) && !aborted; b++) begin
          for (int k = 0; k < e.div && !aborted; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (abort) aborted = 1;
            else if (k == 0) obs[b] = uart_tx;
            else if (uart_tx !== obs[b]) bad = 1;
          end
        end
        if (!aborted) begin
          check_eq("frame", {22'd0, obs}, {22'd0, expw});
          check_eq("bit_hold", {31'd0, bad}, 32'd0);
        end
        in_frame = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s, s0, s1, s2, c, b, base;
    reset          = 1'b1;
    baud_div       = 17'd4;
    flow_en        = 1'b0;
    cts_n          = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    check_eq("rst_line", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);

    // Single byte, latency and busy timing
    start_q.delete();
    base = n_frames;
    push_byte(8'hA5, 4, 1'b1);
    wait_frames(base + 1, 50);
    s = pop_start();
    check_eq("latency", s - last_accept, 2);
    b = cyc;
    while (busy && cyc < s + 200) @(negedge clk);
    b = cyc;
    check_eq("busy_fall", b - s, 40);
    wait_idle(200);

    // Back-to-back frames
    start_q.delete();
    base     = n_frames;
    baud_div = 17'd3;
    push_byte(8'h00, 3, 1'b1);
    push_byte(8'hFF, 3, 1'b1);
    push_byte(8'h55, 3, 1'b1);
    wait_idle(400);
    check_eq("b2b_frames", n_frames, base + 3);
    s0 = pop_start();
    s1 = pop_start();
    s2 = pop_start();
    check_eq("b2b_gap01", s1 - s0, 30);
    check_eq("b2b_gap12", s2 - s1, 30);

    // FIFO full with CTS blocked, then release; one push lands on a pop edge
    start_q.delete();
    base     = n_frames;
    baud_div = 17'd2;
    flow_en  = 1'b1;
    cts_n    = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) push_byte(8'(i * 17 + 3), 2, 1'b1);
    check_eq("full_level", {27'd0, fifo_level}, 32'd16);
    check_eq("full_busy", {31'd0, busy}, 32'd1);
    push_byte(8'hEE, 2, 1'b0);
    check_eq("full_drop_level", {27'd0, fifo_level}, 32'd16);
    repeat (10) @(negedge clk);
    check_eq("cts_blocked", n_frames, base);
    cts_n = 1'b0;
    c     = cyc;
    repeat (22) @(negedge clk);
    check_eq("level_pre", {27'd0, fifo_level}, 32'd15);
    tx_if.tx_data  = 8'h99;
    tx_if.tx_valid = 1'b1;
    sb_q.push_back('{data: 8'h99, div: 2});
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    check_eq("level_pushpop", {27'd0, fifo_level}, 32'd15);
    s = pop_start();
    check_eq("cts_release", s - c, 4);
    wait_idle(1000);
    check_eq("full_frames", n_frames, base + 17);

    // CTS deasserted mid-frame
    start_q.delete();
    base     = n_frames;
    baud_div = 17'd4;
    push_byte(8'h81, 4, 1'b1);
    push_byte(8'h7E, 4, 1'b1);
    wait_frames(base + 1, 50);
    s0 = pop_start();
    while (cyc < s0 + 14) @(negedge clk);
    cts_n = 1'b1;
    while (cyc < s0 + 60) @(negedge clk);
    check_eq("cts_hold_frames", n_frames, base + 1);
    check_eq("cts_hold_level", {27'd0, fifo_level}, 32'd1);
    cts_n = 1'b0;
    c     = cyc;
    wait_frames(base + 2, 50);
    s = pop_start();
    check_eq("cts_resume", s - c, 4);
    wait_idle(200);

    // Divisor clamp and mid-frame change
    start_q.delete();
    base     = n_frames;
    flow_en  = 1'b0;
    baud_div = 17'd0;
    push_byte(8'h3C, 2, 1'b1);
    push_byte(8'hC3, 5, 1'b1);
    wait_frames(base + 1, 50);
    @(negedge clk);
    baud_div = 17'd5;
    wait_idle(300);
    s0 = pop_start();
    s1 = pop_start();
    check_eq("div_clamp_gap", s1 - s0, 20);

    // Reset during bit 3 with four bytes queued
    start_q.delete();
    base     = n_frames;
    baud_div = 17'd4;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h11 * (i + 1)), 4, 1'b1);
    wait_frames(base + 1, 50);
    s0 = pop_start();
    while (cyc < s0 + 17) @(negedge clk);
    check_eq("pre_rst_level", {27'd0, fifo_level}, 32'd4);
    abort = 1;
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    @(negedge clk);
    check_eq("midrst_line", {31'd0, uart_tx}, 32'd1);
    check_eq("midrst_level", {27'd0, fifo_level}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    sb_q.delete();
    abort = 0;
    repeat (100) @(negedge clk);
    check_eq("midrst_frames", n_frames, base + 1);
    check_eq("midrst_idle_line", {31'd0, uart_tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
